// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, data-memory
// wait states, debug halt/single-step and saturating stall/flush counters.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | normal issue; hazards resolved combinationally
//   MEM_WAIT | data memory busy; pipeline frozen until MEM_READY or timeout
//   HALTED   | debug halt or memory timeout; pipeline frozen
//   STEP     | one run-style cycle granted from HALTED by a DBG_STEP edge
module hazard_control_unit #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       RS1_ID,
  input  logic [4:0]       RS2_ID,
  input  logic             USES_RS1_ID,
  input  logic             USES_RS2_ID,
  input  logic [4:0]       RD_EX,
  input  logic             MEMREAD_EX,
  input  logic             BRANCH_TAKEN_EX,
  input  logic             MEM_REQ,
  input  logic             MEM_READY,
  input  logic             DBG_HALT,
  input  logic             DBG_STEP,
  output logic             PC_WRITE,
  output logic             IF_ID_WRITE,
  output logic             ID_EX_WRITE,
  output logic             EX_MEM_WRITE,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_FLUSH,
  output logic             MEM_WB_FLUSH,
  output logic             HALTED_O,
  output logic             MEM_ERROR,
  output logic [CNT_W-1:0] STALL_CYCLES,
  output logic [CNT_W-1:0] FLUSH_COUNT
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALTED   = 2'd2,
    ST_STEP     = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_error_q, mem_error_d;
  logic              step_prev_q, step_prev_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic mem_busy;
  logic load_use;
  logic run_style;
  logic freeze;
  logic apply_branch;
  logic apply_load_use;
  logic step_edge;

  // Hazard classification for the current cycle.
  always_comb begin
    mem_busy = MEM_REQ & ~MEM_READY;
    load_use = MEMREAD_EX & (RD_EX != 5'd0) &
               ((USES_RS1_ID & (RS1_ID == RD_EX)) |
                (USES_RS2_ID & (RS2_ID == RD_EX)));
    run_style = (state_q == ST_RUN) | (state_q == ST_STEP) |
                ((state_q == ST_MEM_WAIT) & MEM_READY);
    freeze         = ~run_style | mem_busy;
    apply_branch   = ~freeze & BRANCH_TAKEN_EX;
    apply_load_use = ~freeze & ~BRANCH_TAKEN_EX & load_use;
    step_edge      = DBG_STEP & ~step_prev_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
      step_prev_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
      step_prev_q <= step_prev_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_error_d = mem_error_q;
    step_prev_d = DBG_STEP;
    unique case (state_q)
      ST_RUN, ST_STEP: begin
        if (mem_busy) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
        end else if (DBG_HALT) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (!MEM_READY) begin
          // wait_cnt_q holds the number of not-ready cycles already completed
          if (wait_cnt_q == WAIT_LAST) begin
            mem_error_d = 1'b1;
            state_d     = ST_HALTED;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else if (DBG_HALT) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALTED: begin
        if (!mem_error_q) begin
          if (!DBG_HALT) begin
            state_d = ST_RUN;
          end else if (step_edge) begin
            state_d = ST_STEP;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!PC_WRITE && (state_q != ST_HALTED) && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (apply_branch && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Pipeline controls; reset forces every stage to hold with a bubble.
  always_comb begin
    PC_WRITE     = 1'b1;
    IF_ID_WRITE  = 1'b1;
    ID_EX_WRITE  = 1'b1;
    EX_MEM_WRITE = 1'b1;
    IF_ID_FLUSH  = 1'b0;
    ID_EX_FLUSH  = 1'b0;
    MEM_WB_FLUSH = 1'b0;
    if (RESET) begin
      PC_WRITE     = 1'b0;
      IF_ID_WRITE  = 1'b0;
      ID_EX_WRITE  = 1'b0;
      EX_MEM_WRITE = 1'b0;
      IF_ID_FLUSH  = 1'b1;
      ID_EX_FLUSH  = 1'b1;
      MEM_WB_FLUSH = 1'b1;
    end else if (freeze) begin
      PC_WRITE     = 1'b0;
      IF_ID_WRITE  = 1'b0;
      ID_EX_WRITE  = 1'b0;
      EX_MEM_WRITE = 1'b0;
      MEM_WB_FLUSH = 1'b1;
    end else if (apply_branch) begin
      IF_ID_FLUSH = 1'b1;
      ID_EX_FLUSH = 1'b1;
    end else if (apply_load_use) begin
      PC_WRITE    = 1'b0;
      IF_ID_WRITE = 1'b0;
      ID_EX_FLUSH = 1'b1;
    end
  end

  always_comb begin
    HALTED_O     = (state_q == ST_HALTED) & ~RESET;
    MEM_ERROR    = mem_error_q & ~RESET;
    STALL_CYCLES = stall_cnt_q;
    FLUSH_COUNT  = flush_cnt_q;
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed scenarios then random traffic, all
// checked each cycle against a behavioural model of the sequencing rules.
module tb_hazard_control_unit;

  localparam int unsigned CNT_W       = 4;
  localparam int unsigned MEM_TIMEOUT = 4;
  localparam longint      CMAX        = (64'd1 << CNT_W) - 1;

  logic             CLK;
  logic             rst;
  logic [4:0]       rs1, rs2, rd;
  logic             u1, u2, memread, br, mreq, mready, halt, stp;
  logic             PC_WRITE, IF_ID_WRITE, ID_EX_WRITE, EX_MEM_WRITE;
  logic             IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH;
  logic             HALTED_O, MEM_ERROR;
  logic [CNT_W-1:0] STALL_CYCLES, FLUSH_COUNT;

  hazard_control_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .CLK(CLK), .RESET(rst),
    .RS1_ID(rs1), .RS2_ID(rs2), .USES_RS1_ID(u1), .USES_RS2_ID(u2),
    .RD_EX(rd), .MEMREAD_EX(memread), .BRANCH_TAKEN_EX(br),
    .MEM_REQ(mreq), .MEM_READY(mready), .DBG_HALT(halt), .DBG_STEP(stp),
    .PC_WRITE(PC_WRITE), .IF_ID_WRITE(IF_ID_WRITE), .ID_EX_WRITE(ID_EX_WRITE),
    .EX_MEM_WRITE(EX_MEM_WRITE), .IF_ID_FLUSH(IF_ID_FLUSH),
    .ID_EX_FLUSH(ID_EX_FLUSH), .MEM_WB_FLUSH(MEM_WB_FLUSH),
    .HALTED_O(HALTED_O), .MEM_ERROR(MEM_ERROR),
    .STALL_CYCLES(STALL_CYCLES), .FLUSH_COUNT(FLUSH_COUNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Behavioural model: pipeline is either halted, waiting on memory, or
  // free-running (STEP behaves exactly like RUN for one cycle).
  bit     m_halted, m_waiting, m_err, m_prev;
  int     m_wait_n;
  longint m_stalls, m_flushes;

  task automatic model_reset();
    m_halted = 0; m_waiting = 0; m_err = 0; m_prev = 0;
    m_wait_n = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic tick();
    bit       hit, busy, active, did_branch;
    bit [6:0] e;
    @(negedge CLK);
    hit    = memread && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    busy   = mreq && !mready;
    active = m_waiting ? mready : !m_halted;
    did_branch = 0;
    // e = {pc, if_id, id_ex, ex_mem, if_id_flush, id_ex_flush, mem_wb_flush}
    if (rst)                  e = 7'b0000_111;
    else if (!active || busy) e = 7'b0000_001;
    else if (br) begin        e = 7'b1111_110; did_branch = 1; end
    else if (hit)             e = 7'b0011_010;
    else                      e = 7'b1111_000;
    chk("ctl", {PC_WRITE, IF_ID_WRITE, ID_EX_WRITE, EX_MEM_WRITE,
                IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH}, e);
    chk("halted", HALTED_O, m_halted && !rst);
    chk("mem_err", MEM_ERROR, m_err && !rst);
    chk("stall_cnt", STALL_CYCLES, m_stalls);
    chk("flush_cnt", FLUSH_COUNT, m_flushes);
    @(posedge CLK);
    if (rst) begin
      model_reset();
    end else begin
      if (!e[6] && !m_halted && m_stalls < CMAX) m_stalls++;
      if (did_branch && m_flushes < CMAX) m_flushes++;
      if (m_halted) begin
        if (!m_err && (!halt || (stp && !m_prev))) m_halted = 0;
      end else if (m_waiting) begin
        if (!mready) begin
          m_wait_n++;
          if (m_wait_n == MEM_TIMEOUT) begin
            m_err = 1; m_waiting = 0; m_halted = 1;
          end
        end else begin
          m_waiting = 0; m_halted = halt;
        end
      end else if (busy) begin
        m_waiting = 1; m_wait_n = 0;
      end else begin
        m_halted = halt;
      end
      m_prev = stp;
    end
    #1;
  endtask

  task automatic idle_inputs();
    rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; memread = 0; br = 0;
    mreq = 0; mready = 0;
  endtask

  initial begin
    int n;
    model_reset();
    idle_inputs();
    halt = 0; stp = 0; rst = 1;
    tick(); tick();
    rst = 0;
    tick();

    // load-use on x5, then the same with x0 as destination
    memread = 1; rd = 5; rs1 = 5; u1 = 1;
    tick();
    idle_inputs();
    tick();
    chk("lu_stall_cnt", STALL_CYCLES, 1);
    memread = 1; rd = 0; rs1 = 0; u1 = 1;
    tick();
    idle_inputs();
    chk("x0_no_stall", STALL_CYCLES, 1);

    // branch coincident with a load-use hit
    memread = 1; rd = 7; rs2 = 7; u2 = 1; br = 1;
    tick();
    idle_inputs();
    tick();
    chk("br_flush_cnt", FLUSH_COUNT, 1);
    chk("br_stall_cnt", STALL_CYCLES, 1);

    // three not-ready MEM_WAIT cycles, then ready
    mreq = 1; mready = 0;
    repeat (4) tick();
    mready = 1;
    tick();
    idle_inputs();
    tick();
    chk("memwait_stalls", STALL_CYCLES, 5);

    // halt, pulsed step, held step, release
    halt = 1;
    tick();
    stp = 1; tick();
    stp = 0; tick();
    tick();
    stp = 1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!HALTED_O) n++;
    end
    chk("step_once", n, 1);
    stp = 0; halt = 0;
    tick();
    chk("resume_run", HALTED_O, 0);

    // stall counter saturation
    memread = 1; rd = 3; rs1 = 3; u1 = 1;
    repeat (20) tick();
    idle_inputs();
    chk("stall_sat", STALL_CYCLES, 15);

    // memory timeout
    mreq = 1; mready = 0;
    repeat (1 + MEM_TIMEOUT) tick();
    chk("timeout_err", MEM_ERROR, 1);
    chk("timeout_halt", HALTED_O, 1);
    idle_inputs(); halt = 0;
    repeat (3) tick();
    chk("err_sticky", HALTED_O, 1);
    rst = 1; tick();
    rst = 0; tick();
    chk("recover_err", MEM_ERROR, 0);
    chk("recover_run", HALTED_O, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 59) == 0);
      rs1     = 5'($urandom_range(0, 3));
      rs2     = 5'($urandom_range(0, 3));
      rd      = 5'($urandom_range(0, 3));
      u1      = 1'($urandom_range(0, 1));
      u2      = 1'($urandom_range(0, 1));
      memread = 1'($urandom_range(0, 1));
      br      = ($urandom_range(0, 4) == 0);
      mreq    = ($urandom_range(0, 2) == 0);
      mready  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 11) == 0) halt = ~halt;
      stp     = 1'($urandom_range(0, 1));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
